etapa_wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: takes the registered MEM/WB outputs, selects the write-back value, and commits it into the 32-entry general-purpose register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass.
- Includes a handshaked register-dump engine so the debug unit can stream all 32 registers out after halt.

---
 rtl/etapa_wb_regfile_if.sv | 24 ++
 rtl/etapa_wb_regfile.sv | 111 +++++++++++
 tb/tb_etapa_wb_regfile.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/etapa_wb_regfile_if.sv
// Register-dump handshake between the write-back register file and the debug unit.
// The debug unit is the master: it requests a dump and paces it with ready.
interface etapa_wb_regfile_if #(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5
);
  logic              i_DumpStart;
  logic              i_DumpReady;
  logic              o_DumpValid;
  logic [RNBITS-1:0] o_DumpAddr;
  logic [NBITS-1:0]  o_DumpData;
  logic              o_DumpLast;
  logic              o_DumpBusy;

  modport master (
    output i_DumpStart, i_DumpReady,
    input  o_DumpValid, o_DumpAddr, o_DumpData, o_DumpLast, o_DumpBusy
  );

  modport slave (
    input  i_DumpStart, i_DumpReady,
    output o_DumpValid, o_DumpAddr, o_DumpData, o_DumpLast, o_DumpBusy
  );
endinterface

// File: rtl/etapa_wb_regfile.sv
// Write-back stage plus general-purpose register file.
// Selects the WB value, commits it, serves two bypassed read ports and
// streams the whole file out to the debug unit on request.
module etapa_wb_regfile #(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NBITS-1:0]  i_ALU,
  input  logic [NBITS-1:0]  i_DatoMemoria,
  input  logic [RNBITS-1:0] i_RegistroDestino,
  input  logic              i_MemToReg,
  input  logic              i_RegWrite,
  input  logic [RNBITS-1:0] i_RegA,
  input  logic [RNBITS-1:0] i_RegB,
  output logic [NBITS-1:0]  o_DatoA,
  output logic [NBITS-1:0]  o_DatoB,
  output logic [NBITS-1:0]  o_WBDato,
  output logic              o_WBEnable,
  etapa_wb_regfile_if.slave dump
);

  localparam int                DEPTH = 2**RNBITS;
  localparam logic [RNBITS-1:0] LAST  = '1;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  logic [NBITS-1:0]  r_regs [DEPTH];
  state_t            r_state, w_state_nxt;
  logic [RNBITS-1:0] r_ptr, w_ptr_nxt;
  logic [NBITS-1:0]  w_wb_dato;
  logic              w_wb_en;

  assign w_wb_dato  = i_MemToReg ? i_DatoMemoria : i_ALU;
  assign w_wb_en    = i_RegWrite && (i_RegistroDestino != '0);
  assign o_WBDato   = w_wb_dato;
  assign o_WBEnable = w_wb_en;

  // Shared read rule: R0 is hardwired zero, a same-cycle write wins over the array.
  function automatic logic [NBITS-1:0] f_read(input logic [RNBITS-1:0] a);
    if (a == '0)                               return '0;
    else if (w_wb_en && a == i_RegistroDestino) return w_wb_dato;
    else                                       return r_regs[a];
  endfunction

  // Commit the write-back value; the dump engine never blocks this.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
    end else if (w_wb_en) begin
      r_regs[i_RegistroDestino] <= w_wb_dato;
    end
  end

  // Read ports and dump data, all through the bypassed read (always_comb so
  // the function's reads of the array and WB signals are in the sensitivity).
  always_comb begin
    o_DatoA         = f_read(i_RegA);
    o_DatoB         = f_read(i_RegB);
    dump.o_DumpData = f_read(r_ptr);
  end

  // Dump FSM state and pointer registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Dump FSM next state: start only from IDLE, advance on ready, exit after the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (dump.i_DumpStart) begin
          w_state_nxt = SEND;
          w_ptr_nxt   = '0;
        end
      end
      SEND: begin
        if (dump.i_DumpReady) begin
          if (r_ptr == LAST) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Dump handshake outputs; ptr rests at 0 in IDLE so addr reads 0 there.
  always_comb begin
    dump.o_DumpValid = (r_state == SEND);
    dump.o_DumpBusy  = (r_state != IDLE);
    dump.o_DumpAddr  = r_ptr;
    dump.o_DumpLast  = (r_state == SEND) && (r_ptr == LAST);
  end

endmodule

// File: tb/tb_etapa_wb_regfile.sv
// Directed bench for etapa_wb_regfile: inputs change on the falling edge,
// outputs are checked 1ns later, commits happen on the rising edge.
module tb_etapa_wb_regfile;
  localparam int NBITS  = 32;
  localparam int RNBITS = 5;

  logic              clk;
  logic              rst_n;
  logic [NBITS-1:0]  alu, mem;
  logic [RNBITS-1:0] dest, rega, regb;
  logic              m2r, rw;
  logic [NBITS-1:0]  dato_a, dato_b, wb_dato;
  logic              wb_en;
  int                checks, failures;

  etapa_wb_regfile_if #(.NBITS(NBITS), .RNBITS(RNBITS)) dump_if ();

  etapa_wb_regfile #(.NBITS(NBITS), .RNBITS(RNBITS)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_ALU(alu), .i_DatoMemoria(mem), .i_RegistroDestino(dest),
    .i_MemToReg(m2r), .i_RegWrite(rw),
    .i_RegA(rega), .i_RegB(regb),
    .o_DatoA(dato_a), .o_DatoB(dato_b),
    .o_WBDato(wb_dato), .o_WBEnable(wb_en),
    .dump(dump_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wb_write(input logic [RNBITS-1:0] d, input logic [NBITS-1:0] v);
    rw = 1'b1; m2r = 1'b0; dest = d; alu = v;
    @(negedge clk);
    rw = 1'b0; alu = '0; dest = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; #1;
    if (dump_if.o_DumpValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dump_if.o_DumpValid); end
    checks++;
    if (dump_if.o_DumpBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dump_if.o_DumpBusy); end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    wb_write(5'd3, 32'h55);
    rega = 5'd3; #1;
    if (dato_a !== 32'h55) begin failures++; $display("FAIL pre_reset_r3 got=%h exp=00000055", dato_a); end
    checks++;
    rst_n = 1'b0; #1;
    if (dato_a !== 32'h0) begin failures++; $display("FAIL reset_async_r3 got=%h exp=0", dato_a); end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rega = a[RNBITS-1:0]; regb = 5'(31 - a); #1;
      if (dato_a !== 32'h0 || dato_b !== 32'h0) begin
        failures++; $display("FAIL reset_read a=%0d gotA=%h gotB=%h exp=0", a, dato_a, dato_b);
      end
      checks++;
    end
    if (dump_if.o_DumpValid !== 1'b0 || dump_if.o_DumpAddr !== 5'd0 || dump_if.o_DumpLast !== 1'b0) begin
      failures++; $display("FAIL reset_dump_idle valid=%b addr=%0d last=%b exp=0/0/0",
        dump_if.o_DumpValid, dump_if.o_DumpAddr, dump_if.o_DumpLast);
    end
    checks++;
  endtask

  task automatic test_write_read;
    @(negedge clk);
    rw = 1'b1; dest = 5'd5; m2r = 1'b0; alu = 32'h0000_1234; mem = 32'hFFFF_0000;
    rega = 5'd5; regb = 5'd4; #1;
    if (dato_a !== 32'h1234) begin failures++; $display("FAIL bypass_a got=%h exp=00001234", dato_a); end
    checks++;
    if (dato_b !== 32'h0) begin failures++; $display("FAIL bypass_other_b got=%h exp=0", dato_b); end
    checks++;
    if (wb_en !== 1'b1 || wb_dato !== 32'h1234) begin
      failures++; $display("FAIL wb_alu en=%b dato=%h exp=1/00001234", wb_en, wb_dato);
    end
    checks++;
    @(negedge clk);
    rw = 1'b0; alu = 32'h0; regb = 5'd5; #1;
    if (dato_a !== 32'h1234 || dato_b !== 32'h1234) begin
      failures++; $display("FAIL array_r5 gotA=%h gotB=%h exp=00001234", dato_a, dato_b);
    end
    checks++;
  endtask

  task automatic test_load_r0;
    @(negedge clk);
    rw = 1'b1; m2r = 1'b1; mem = 32'hDEAD_BEEF; alu = 32'h1111_1111; dest = 5'd0; rega = 5'd0; #1;
    if (wb_en !== 1'b0) begin failures++; $display("FAIL r0_wben got=%b exp=0", wb_en); end
    checks++;
    if (wb_dato !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_sel got=%h exp=deadbeef", wb_dato); end
    checks++;
    if (dato_a !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%h exp=0", dato_a); end
    checks++;
    @(negedge clk);
    dest = 5'd31; rega = 5'd31; regb = 5'd0; #1;
    if (dato_a !== 32'hDEAD_BEEF || wb_en !== 1'b1) begin
      failures++; $display("FAIL r31_bypass got=%h en=%b exp=deadbeef/1", dato_a, wb_en);
    end
    checks++;
    if (dato_b !== 32'h0) begin failures++; $display("FAIL r0_after_write got=%h exp=0", dato_b); end
    checks++;
    @(negedge clk);
    rw = 1'b0; m2r = 1'b0; mem = 32'h0; dest = 5'd0; #1;
    if (dato_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL r31_array got=%h exp=deadbeef", dato_a); end
    checks++;
  endtask

  task automatic test_dump_backpressure;
    int idx, cyc;
    logic rdy;
    for (int k = 1; k < 32; k++) wb_write(k[RNBITS-1:0], 32'(k * 3));
    dump_if.i_DumpStart = 1'b1;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 32 && cyc < 200) begin
      rdy = cyc[0];
      dump_if.i_DumpReady = rdy; #1;
      if (dump_if.o_DumpValid !== 1'b1 || dump_if.o_DumpAddr !== idx[RNBITS-1:0]) begin
        failures++; $display("FAIL bp_addr valid=%b addr=%0d exp=1/%0d", dump_if.o_DumpValid, dump_if.o_DumpAddr, idx);
      end
      checks++;
      if (dump_if.o_DumpData !== 32'(idx * 3)) begin
        failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", idx, dump_if.o_DumpData, 32'(idx * 3));
      end
      checks++;
      if (dump_if.o_DumpLast !== (idx == 31)) begin
        failures++; $display("FAIL bp_last idx=%0d got=%b", idx, dump_if.o_DumpLast);
      end
      checks++;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    dump_if.i_DumpReady = 1'b0; #1;
    if (idx != 32) begin failures++; $display("FAIL bp_count got=%0d exp=32", idx); end
    checks++;
    if (dump_if.o_DumpValid !== 1'b0 || dump_if.o_DumpBusy !== 1'b0) begin
      failures++; $display("FAIL bp_idle valid=%b busy=%b exp=0/0", dump_if.o_DumpValid, dump_if.o_DumpBusy);
    end
    checks++;
  endtask

  task automatic test_write_during_dump;
    int guard;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b1;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b0; dump_if.i_DumpReady = 1'b1;
    repeat (7) @(negedge clk);
    dump_if.i_DumpReady = 1'b0; #1;
    if (dump_if.o_DumpAddr !== 5'd7 || dump_if.o_DumpData !== 32'd21) begin
      failures++; $display("FAIL wdd_stall addr=%0d data=%h exp=7/00000015", dump_if.o_DumpAddr, dump_if.o_DumpData);
    end
    checks++;
    @(negedge clk);
    rw = 1'b1; dest = 5'd7; alu = 32'hA5A5_0007; #1;
    if (dump_if.o_DumpData !== 32'hA5A5_0007 || dump_if.o_DumpAddr !== 5'd7) begin
      failures++; $display("FAIL wdd_bypass addr=%0d data=%h exp=7/a5a50007", dump_if.o_DumpAddr, dump_if.o_DumpData);
    end
    checks++;
    @(negedge clk);
    rw = 1'b0; dest = 5'd0; alu = 32'h0; dump_if.i_DumpReady = 1'b1; #1;
    if (dump_if.o_DumpData !== 32'hA5A5_0007 || dump_if.o_DumpAddr !== 5'd7) begin
      failures++; $display("FAIL wdd_accept addr=%0d data=%h exp=7/a5a50007", dump_if.o_DumpAddr, dump_if.o_DumpData);
    end
    checks++;
    @(negedge clk); #1;
    if (dump_if.o_DumpAddr !== 5'd8 || dump_if.o_DumpData !== 32'd24) begin
      failures++; $display("FAIL wdd_next addr=%0d data=%h exp=8/00000018", dump_if.o_DumpAddr, dump_if.o_DumpData);
    end
    checks++;
    guard = 0;
    while (dump_if.o_DumpValid === 1'b1 && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    if (dump_if.o_DumpBusy !== 1'b0 || guard != 24) begin
      failures++; $display("FAIL wdd_finish busy=%b cycles=%0d exp=0/24", dump_if.o_DumpBusy, guard);
    end
    checks++;
    dump_if.i_DumpReady = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b1;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b0; dump_if.i_DumpReady = 1'b1;
    repeat (31) @(negedge clk);
    #1;
    if (dump_if.o_DumpAddr !== 5'd31 || dump_if.o_DumpLast !== 1'b1) begin
      failures++; $display("FAIL b2b_last addr=%0d last=%b exp=31/1", dump_if.o_DumpAddr, dump_if.o_DumpLast);
    end
    checks++;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b1; #1;
    if (dump_if.o_DumpValid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", dump_if.o_DumpValid); end
    checks++;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b0; dump_if.i_DumpReady = 1'b0; #1;
    if (dump_if.o_DumpValid !== 1'b1 || dump_if.o_DumpAddr !== 5'd0) begin
      failures++; $display("FAIL b2b_restart valid=%b addr=%0d exp=1/0", dump_if.o_DumpValid, dump_if.o_DumpAddr);
    end
    checks++;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_abort_ignore;
    for (int k = 1; k < 16; k++) wb_write(k[RNBITS-1:0], 32'(k * 3));
    dump_if.i_DumpStart = 1'b1;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b0; dump_if.i_DumpReady = 1'b1;
    repeat (3) @(negedge clk);
    dump_if.i_DumpStart = 1'b1;
    @(negedge clk);
    dump_if.i_DumpStart = 1'b0; #1;
    if (dump_if.o_DumpAddr !== 5'd4 || dump_if.o_DumpValid !== 1'b1) begin
      failures++; $display("FAIL ignore_start addr=%0d valid=%b exp=4/1", dump_if.o_DumpAddr, dump_if.o_DumpValid);
    end
    checks++;
    repeat (8) @(negedge clk);
    dump_if.i_DumpReady = 1'b0; #1;
    if (dump_if.o_DumpAddr !== 5'd12 || dump_if.o_DumpData !== 32'd36) begin
      failures++; $display("FAIL abort_at12 addr=%0d data=%h exp=12/00000024", dump_if.o_DumpAddr, dump_if.o_DumpData);
    end
    checks++;
    rst_n = 1'b0; #1;
    if (dump_if.o_DumpValid !== 1'b0 || dump_if.o_DumpBusy !== 1'b0 || dump_if.o_DumpAddr !== 5'd0) begin
      failures++; $display("FAIL abort_async valid=%b busy=%b addr=%0d exp=0/0/0",
        dump_if.o_DumpValid, dump_if.o_DumpBusy, dump_if.o_DumpAddr);
    end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    dump_if.i_DumpReady = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      if (dump_if.o_DumpValid !== 1'b0) begin failures++; $display("FAIL abort_no_words got=%b exp=0", dump_if.o_DumpValid); end
      checks++;
    end
    for (int a = 1; a < 16; a++) begin
      rega = a[RNBITS-1:0]; regb = a[RNBITS-1:0]; #1;
      if (dato_a !== 32'h0 || dato_b !== 32'h0) begin
        failures++; $display("FAIL abort_clear a=%0d gotA=%h gotB=%h exp=0", a, dato_a, dato_b);
      end
      checks++;
    end
    dump_if.i_DumpReady = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; alu = '0; mem = '0; dest = '0; rega = '0; regb = '0; m2r = 1'b0; rw = 1'b0;
    dump_if.i_DumpStart = 1'b0; dump_if.i_DumpReady = 1'b0;
    @(negedge clk);
    test_reset;
    test_write_read;
    test_load_r0;
    test_dump_backpressure;
    test_write_during_dump;
    test_back_to_back;
    test_abort_ignore;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
